seg7_bcd_capture: RTL
=====================

SEG7_BCD_CAPTURE -- requirements
Module: seg7_bcd_capture

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, giving the number of consecutive identical samples required to accept a digit (legal range 2..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port seg, input, 7 bits: sniffed segment lines {a,b,c,d,e,f,g}, active-high, bit 6 = a.
REQ-005 SHALL have port dig_en, input, 4 bits: active-high digit strobes of the multiplexed display; bit i selects digit i.
REQ-006 SHALL have port out_ready, input, 1 bit: the consumer accepts the frame.
REQ-007 SHALL have port bcd, output, 16 bits: captured frame; digit i on bcd[4i+3:4i].
REQ-008 SHALL have port out_valid, output, 1 bit: bcd and frame_err are valid.
REQ-009 SHALL have port frame_err, output, 1 bit: at least one digit in the presented frame had an undecodable pattern.
REQ-010 SHALL have port ovf, output, 1 bit: one-cycle pulse when a completed frame is dropped.

Function
REQ-011 SHALL register (dig_en, seg) each cycle and compare the current sample with the previous sample.
REQ-012 SHALL increment a stability counter when dig_en is one-hot and the sample equals the previous one; otherwise it SHALL reload the counter to 1 if dig_en is one-hot, or to 0 if it is not.
REQ-013 SHALL saturate the stability counter at STABLE_CNT and SHALL capture only on the cycle it first reaches STABLE_CNT, capturing at most once per stable run.
REQ-014 SHALL, on capture, write the decoded nibble into slot i for the active strobe bit i and set captured-mask bit i; a repeat capture of the same slot SHALL overwrite it.
REQ-015 SHALL decode 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
REQ-016 SHALL decode any other pattern, including 0000000, to 4'hF and set that slot's error bit.
REQ-017 SHALL declare a frame complete when all 4 captured-mask bits are set, and SHALL clear the mask and the error bits in the same cycle.
REQ-018 SHALL implement FSM states COLLECT (out_valid=0) and HOLD (out_valid=1).
REQ-019 In COLLECT, on frame completion, SHALL load bcd and frame_err (OR of the slot error bits) and go to HOLD on the next edge.
REQ-020 In HOLD, when out_ready=1 and no frame completes, SHALL return to COLLECT.
REQ-021 In HOLD, when out_ready=1 and a frame completes in the same cycle, SHALL load the new frame and stay in HOLD, with no ovf.
REQ-022 In HOLD, when out_ready=0 and a frame completes, SHALL drop the new frame, pulse ovf for one cycle, and leave bcd, frame_err and out_valid unchanged.
REQ-023 SHALL keep bcd and frame_err stable while out_valid=1 and out_ready=0.
REQ-024 SHALL continue sampling and capturing in both states.
REQ-025 SHALL have a latency of STABLE_CNT+1 cycles from the first sample of the final digit's stable run to out_valid rising.

Reset
REQ-026 Asserting rst SHALL immediately force the FSM to COLLECT and clear bcd, frame_err, out_valid, ovf, the captured mask, the slot error bits, the stability counter and the sample registers to 0.
REQ-027 Reset asserted mid-frame SHALL discard any partial capture; after release, collection SHALL restart from an empty mask.

Configuration
REQ-028 Macro SEG7_ALT_GLYPH_EN defined: SHALL additionally decode 0011111->6, 1110010->7 and 1110011->9 as valid, without setting error bits.
REQ-029 Macro SEG7_ALT_GLYPH_EN undefined: these three patterns SHALL decode to 4'hF and set error bits, per REQ-016.

Verification
REQ-030 Bench SHALL cover: scan digits 3,2,1,0 with patterns 1111001, 1101101, 0110000, 1111110, each held 6 cycles, out_ready=1 -> bcd=16'h3210, frame_err=0, one out_valid cycle, ovf=0.
REQ-031 Bench SHALL cover: digit strobe held for only STABLE_CNT-1 cycles -> no capture and no out_valid; dig_en=4'b0011 -> counter cleared, no capture.
REQ-032 Bench SHALL cover: digit 2 driven with 1000001 -> bcd[11:8]=4'hF and frame_err=1; the next clean frame -> frame_err=0.
REQ-033 Bench SHALL cover: out_ready=0 while two complete frames 16'h1234 and 16'h5678 arrive -> bcd holds 16'h1234, ovf pulses once; then out_ready=1 -> out_valid falls.
REQ-034 Bench SHALL cover: out_ready=1 in the cycle frame 16'h9999 completes during HOLD -> bcd becomes 16'h9999, out_valid stays 1, ovf=0.
REQ-035 Bench SHALL cover: rst pulse after 2 digits captured -> all outputs 0; next full 4-digit scan -> correct frame; pattern 0011111 -> 6 with SEG7_ALT_GLYPH_EN defined, 4'hF with error set without it.

Source files
------------

// File: rtl/seg7_bcd_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg7_bcd_capture
// Description : Sniffs a 4-digit multiplexed 7-segment display bus and turns
//               it back into a 16-bit BCD frame. A digit is accepted only after
//               its (dig_en, seg) sample has been stable for STABLE_CNT
//               consecutive cycles with a one-hot strobe. When all four digit
//               slots have been captured, the frame is presented on a
//               valid/ready output. A frame that completes while the previous
//               one is still unconsumed is dropped and flagged on ovf.
//
// Parameters  : STABLE_CNT  consecutive identical samples needed (2..15)
// Ports       : clk         clock, rising edge
//               rst         asynchronous active-high reset
//               seg[6:0]    segment lines {a,b,c,d,e,f,g}, bit 6 = a
//               dig_en[3:0] digit strobes, bit i selects digit i
//               out_ready   consumer accepts the presented frame
//               bcd[15:0]   captured frame, digit i on bcd[4i+3:4i]
//               out_valid   bcd / frame_err are valid
//               frame_err   some digit in the frame was undecodable
//               ovf         one-cycle pulse when a completed frame is dropped
// Options     : SEG7_ALT_GLYPH_EN  also accept the alternative 6, 7 and 9
//                                  glyphs (0011111, 1110010, 1110011)
// Revision    : 1.0  initial release
// ============================================================================
module seg7_bcd_capture #(
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_en,
  input  logic        out_ready,
  output logic [15:0] bcd,
  output logic        out_valid,
  output logic        frame_err,
  output logic        ovf
);

  localparam logic [3:0] c_stable_cnt = 4'(STABLE_CNT);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Returns {err, nibble}; anything that is not a known glyph maps to F.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'b1111110: decode = {1'b0, 4'd0};
      7'b0110000: decode = {1'b0, 4'd1};
      7'b1101101: decode = {1'b0, 4'd2};
      7'b1111001: decode = {1'b0, 4'd3};
      7'b0110011: decode = {1'b0, 4'd4};
      7'b1011011: decode = {1'b0, 4'd5};
      7'b1011111: decode = {1'b0, 4'd6};
      7'b1110000: decode = {1'b0, 4'd7};
      7'b1111111: decode = {1'b0, 4'd8};
      7'b1111011: decode = {1'b0, 4'd9};
`ifdef SEG7_ALT_GLYPH_EN
      7'b0011111: decode = {1'b0, 4'd6};
      7'b1110010: decode = {1'b0, 4'd7};
      7'b1110011: decode = {1'b0, 4'd9};
`endif
      default:    decode = {1'b1, 4'hF};
    endcase
  endfunction

  // Sampling and stability tracking
  logic [3:0]  r_samp_en;
  logic [6:0]  r_samp_seg;
  logic [3:0]  r_cnt;
  logic        r_hit;
  logic [3:0]  w_cnt_next;
  logic        w_hit_next;
  logic        w_onehot;
  logic        w_same;

  // Frame assembly
  logic [3:0]  r_mask;
  logic [3:0]  r_err;
  logic [3:0]  r_slot [4];
  logic [3:0]  w_cap_en;
  logic [4:0]  w_dec;
  logic        w_complete;

  // Output side
  state_t      r_state;
  state_t      w_state_next;
  logic        w_load;
  logic        w_drop;
  logic [15:0] r_bcd;
  logic        r_ferr;
  logic        r_ovf;

  assign w_onehot = (dig_en != 4'd0) && ((dig_en & (dig_en - 4'd1)) == 4'd0);
  assign w_same   = ({dig_en, seg} == {r_samp_en, r_samp_seg});

  always_comb begin
    w_cnt_next = 4'd0;
    if (w_onehot) begin
      if (w_same) begin
        w_cnt_next = (r_cnt == c_stable_cnt) ? r_cnt : r_cnt + 4'd1;
      end else begin
        w_cnt_next = 4'd1;
      end
    end
  end

  // Hit fires only on the transition into saturation, so a long stable run
  // captures exactly once.
  assign w_hit_next = (w_cnt_next == c_stable_cnt) && (r_cnt != c_stable_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp_en  <= 4'd0;
      r_samp_seg <= 7'd0;
      r_cnt      <= 4'd0;
      r_hit      <= 1'b0;
    end else begin
      r_samp_en  <= dig_en;
      r_samp_seg <= seg;
      r_cnt      <= w_cnt_next;
      r_hit      <= w_hit_next;
    end
  end

  // r_samp_* still holds the stable run's value in the cycle r_hit is high,
  // and that value is guaranteed one-hot.
  assign w_dec      = decode(r_samp_seg);
  assign w_cap_en   = r_hit ? r_samp_en : 4'd0;
  assign w_complete = &r_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= 4'd0;
      r_err  <= 4'd0;
    end else if (w_complete) begin
      r_mask <= 4'd0;
      r_err  <= 4'd0;
    end else begin
      r_mask <= r_mask | w_cap_en;
      // A repeat capture replaces the slot's error state as well as its value.
      r_err  <= (r_err & ~w_cap_en) | (w_dec[4] ? w_cap_en : 4'd0);
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_slot[gi] <= 4'd0;
      end else if (w_cap_en[gi]) begin
        r_slot[gi] <= w_dec[3:0];
      end
    end
  end

  // Output handshake FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_complete) begin
          w_load       = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (w_complete) begin
            w_load = 1'b1;
          end else begin
            w_state_next = COLLECT;
          end
        end else if (w_complete) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd  <= 16'd0;
      r_ferr <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_load) begin
        r_bcd  <= {r_slot[3], r_slot[2], r_slot[1], r_slot[0]};
        r_ferr <= |r_err;
      end
      r_ovf <= w_drop;
    end
  end

  assign bcd       = r_bcd;
  assign frame_err = r_ferr;
  assign ovf       = r_ovf;
  assign out_valid = (r_state == HOLD);

endmodule
`default_nettype wire
